// File: rtl/avalon_st_channel_filter_buffered.sv
// rtl/avalon_st_channel_filter_buffered.sv - Avalon-ST channel narrowing filter with 2-entry skid buffer
module avalon_st_channel_filter_buffered #(
  parameter int DATA_W      = 8,
  parameter int IN_CHAN_W   = 8,
  parameter int OUT_CHAN_W  = 1,
  parameter int MAX_CHANNEL = 0,
  parameter int DROP_MODE   = 1,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic                  in_ready,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [IN_CHAN_W-1:0]  in_channel,
  input  logic                  in_startofpacket,
  input  logic                  in_endofpacket,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic [OUT_CHAN_W-1:0] out_channel,
  output logic                  out_startofpacket,
  output logic                  out_endofpacket,
  output logic [CNT_W-1:0]      drop_count,
  output logic                  protocol_err
);

  if (MAX_CHANNEL >= (2 ** OUT_CHAN_W)) begin : g_max_channel_check
    $error("MAX_CHANNEL does not fit in OUT_CHAN_W bits");
  end

  // Buffer entry layout: {data, channel, sop, eop}
  localparam int ENTRY_W = DATA_W + OUT_CHAN_W + 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PASS = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  localparam logic [IN_CHAN_W-1:0] MAX_CH = IN_CHAN_W'(MAX_CHANNEL);

  logic [ENTRY_W-1:0] head_q, head_d;
  logic [ENTRY_W-1:0] tail_q, tail_d;
  logic [1:0]         count_q, count_d;
  logic               in_ready_q, in_ready_d;
  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   drop_count_q, drop_count_d;
  logic               protocol_err_q, protocol_err_d;

  logic               accept;
  logic               in_range;
  logic               pop;
  logic               keep;
  logic               drop_inc;
  logic [ENTRY_W-1:0] in_entry;

  assign accept   = in_valid & in_ready_q;
  assign in_range = (in_channel <= MAX_CH);
  assign pop      = (count_q != 2'd0) & out_ready;
  assign in_entry = {in_data, in_channel[OUT_CHAN_W-1:0], in_startofpacket, in_endofpacket};

  // Keep/discard decision for the accepted beat and packet-level state tracking
  always_comb begin
    keep           = 1'b0;
    drop_inc       = 1'b0;
    protocol_err_d = 1'b0;
    state_d        = state_q;
    if (accept) begin
      if (DROP_MODE == 0) begin
        keep     = in_range;
        drop_inc = ~in_range;
      end else if (in_startofpacket) begin
        // A SOP always opens a new packet, even if the previous one never ended
        protocol_err_d = (state_q != ST_IDLE);
        keep           = in_range;
        drop_inc       = ~in_range;
        if (in_endofpacket) begin
          state_d = ST_IDLE;
        end else begin
          state_d = in_range ? ST_PASS : ST_DROP;
        end
      end else begin
        case (state_q)
          ST_PASS: begin
            keep = 1'b1;
            if (in_endofpacket) state_d = ST_IDLE;
          end
          ST_DROP: begin
            if (in_endofpacket) state_d = ST_IDLE;
          end
          default: begin
            // Orphan beat outside any packet: silently discarded
            state_d = ST_IDLE;
          end
        endcase
      end
    end
  end

  // Saturating drop counter
  always_comb begin
    drop_count_d = drop_count_q;
    if (drop_inc && (drop_count_q != {CNT_W{1'b1}})) begin
      drop_count_d = drop_count_q + CNT_W'(1);
    end
  end

  // Two-entry skid buffer; a store never happens when full because in_ready is low then
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case (count_q)
      2'd0: begin
        if (keep) begin
          head_d  = in_entry;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (pop && keep) begin
          head_d = in_entry;
        end else if (pop) begin
          count_d = 2'd0;
        end else if (keep) begin
          tail_d  = in_entry;
          count_d = 2'd2;
        end
      end
      default: begin
        if (pop) begin
          head_d  = tail_q;
          count_d = 2'd1;
        end
      end
    endcase
    in_ready_d = (count_d != 2'd2);
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= 2'd0;
      in_ready_q     <= 1'b0;
      state_q        <= ST_IDLE;
      drop_count_q   <= '0;
      protocol_err_q <= 1'b0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      in_ready_q     <= in_ready_d;
      state_q        <= state_d;
      drop_count_q   <= drop_count_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  assign in_ready          = in_ready_q;
  assign out_valid         = (count_q != 2'd0);
  assign out_data          = head_q[ENTRY_W-1 -: DATA_W];
  assign out_channel       = head_q[OUT_CHAN_W+1:2];
  assign out_startofpacket = head_q[1];
  assign out_endofpacket   = head_q[0];
  assign drop_count        = drop_count_q;
  assign protocol_err      = protocol_err_q;

endmodule
